// File: rtl/game_pkg.sv
// Shared game-state encodings and scroll-step defaults for the dino runner.
// The top level and the background/obstacle delegates all decode gameState from here.
package game_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DEAD = 2'b10;

   localparam int DX_W            = 4;
   localparam int DX_INIT_DEFAULT = 5;
   localparam int DX_MAX_DEFAULT  = 12;

   typedef enum logic [1:0] {
      GS_IDLE    = ST_IDLE,
      GS_RUN     = ST_RUN,
      GS_DEAD    = ST_DEAD,
      GS_ILLEGAL = 2'b11
   } gameState_e;

   // Width of an unsigned counter that must hold 0..maxVal; never narrower than 1 bit.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous level into the clk domain and emits a one-clk
// registered pulse on each rising edge of the synchronised level.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic asyncIn,
   output logic rise
);

   logic syncMeta;
   logic syncStable;
   logic prevLevel;

   // Two flops absorb metastability; the third stage remembers the last level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncMeta   <= 1'b0;
         syncStable <= 1'b0;
         prevLevel  <= 1'b0;
         rise       <= 1'b0;
      end else begin
         syncMeta   <= asyncIn;
         syncStable <= syncMeta;
         prevLevel  <= syncStable;
         rise       <= syncStable & ~prevLevel;
      end
   end

endmodule

// File: rtl/game_state_controller.sv
// Game-state FSM (IDLE/RUN/DEAD), frame-granular collision detection and the
// scroll-speed ramp feeding the background and obstacle delegates.
module game_state_controller
   import game_pkg::*;
#(
   parameter int DEAD_HOLDOFF_FRAMES = 30,
   parameter int SPEED_STEP_FRAMES   = 600,
   parameter int DX_INIT             = DX_INIT_DEFAULT,
   parameter int DX_MAX              = DX_MAX_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_clk,
   input  logic            jump,
   input  logic            dino_pix,
   input  logic            obstacle_pix,
   output logic [1:0]      gameState,
   output logic [DX_W-1:0] dx,
   output logic            frame_tick,
   output logic            collided
);

   localparam int HW = cntWidth(DEAD_HOLDOFF_FRAMES);
   localparam int SW = cntWidth(SPEED_STEP_FRAMES);

   localparam logic [HW-1:0]   HOLD_LAST  = HW'(DEAD_HOLDOFF_FRAMES);
   localparam logic [SW-1:0]   SPEED_LAST = SW'(SPEED_STEP_FRAMES - 1);
   localparam logic [DX_W-1:0] DX_START   = DX_W'(DX_INIT);
   localparam logic [DX_W-1:0] DX_CEIL    = DX_W'(DX_MAX);

   gameState_e    state;
   logic          jumpRise;
   logic          hit;
   logic          hitPending;
   logic [HW-1:0] holdoffCnt;
   logic [SW-1:0] speedCnt;

   edge_sync frameSync (
      .clk     (clk),
      .rst     (rst),
      .asyncIn (frame_clk),
      .rise    (frame_tick)
   );

   edge_sync jumpSync (
      .clk     (clk),
      .rst     (rst),
      .asyncIn (jump),
      .rise    (jumpRise)
   );

   assign hit       = dino_pix & obstacle_pix;
   assign gameState = state;

   // A hit only latches while running and is judged at the frame boundary, so a frame that
   // ends with a hit in its last clk still kills; in DEAD the holdoff gates revival and dx freezes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= GS_IDLE;
         dx         <= DX_START;
         collided   <= 1'b0;
         hitPending <= 1'b0;
         holdoffCnt <= '0;
         speedCnt   <= '0;
      end else begin
         case (state)
            GS_IDLE: begin
               hitPending <= 1'b0;
               if (jumpRise) begin
                  state <= GS_RUN;
               end
            end
            GS_RUN: begin
               if (frame_tick) begin
                  hitPending <= 1'b0;
                  if (speedCnt == SPEED_LAST) begin
                     speedCnt <= '0;
                     if (dx < DX_CEIL) begin
                        dx <= dx + DX_W'(1);
                     end
                  end else begin
                     speedCnt <= speedCnt + SW'(1);
                  end
                  if (hitPending || hit) begin
                     state      <= GS_DEAD;
                     collided   <= 1'b1;
                     holdoffCnt <= '0;
                  end
               end else if (hit) begin
                  hitPending <= 1'b1;
               end
            end
            GS_DEAD: begin
               hitPending <= 1'b0;
               if (jumpRise && (holdoffCnt == HOLD_LAST)) begin
                  state    <= GS_IDLE;
                  collided <= 1'b0;
                  dx       <= DX_START;
                  speedCnt <= '0;
               end else if (frame_tick && (holdoffCnt != HOLD_LAST)) begin
                  holdoffCnt <= holdoffCnt + HW'(1);
               end
            end
            default: begin
               state      <= GS_IDLE;
               collided   <= 1'b0;
               dx         <= DX_START;
               speedCnt   <= '0;
               hitPending <= 1'b0;
            end
         endcase
      end
   end

endmodule
